// File: rtl/idex_ctrl_stage.sv
// ID/EX control stage: decodes RV32I ALU/LW/SW words and registers the EX control bundle.
// Define ILLEGAL_INSN_TRAP_EN to flag undecodable instructions (ex_illegal, illegal_sticky).
module idex_ctrl_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_instr,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_ctrl,
    output logic              ex_alu_src_a,
    output logic [2:0]        ex_alu_src_b,
    output logic              ex_dmem_reb,
    output logic              ex_dmem_web,
    output logic              ex_dmem_alu_sel,
    output logic              ex_ls_mux_sel,
    output logic              ex_reg_we,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [XLEN-1:0]   ex_imm,
    output logic              ex_illegal,
    output logic              illegal_sticky,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    localparam logic [2:0] SRC_B_RS2   = 3'b000;
    localparam logic [2:0] SRC_B_IIMM  = 3'b010;
    localparam logic [2:0] SRC_B_LSIMM = 3'b011;
    localparam logic [2:0] SRC_B_SHAMT = 3'b100;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] id_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [XLEN-1:0]   i_imm;
    logic [XLEN-1:0]   s_imm;
    logic [XLEN-1:0]   shamt;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign funct7 = id_instr[31:25];
    assign id_rd  = REG_AW'(id_instr[11:7]);
    assign id_rs1 = REG_AW'(id_instr[19:15]);
    assign id_rs2 = REG_AW'(id_instr[24:20]);
    assign i_imm  = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
    assign s_imm  = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign shamt  = {{(XLEN-5){1'b0}}, id_instr[24:20]};

    logic            dec_legal;
    logic [3:0]      dec_alu;
    logic [2:0]      dec_src_b;
    logic            dec_reb;
    logic            dec_web;
    logic            dec_dsel;
    logic            dec_lsel;
    logic            dec_we;
    logic [XLEN-1:0] dec_imm;
    logic            dec_uses_rs2;

    always_comb begin
        dec_legal    = 1'b0;
        dec_alu      = ALU_ADD;
        dec_src_b    = SRC_B_RS2;
        dec_reb      = 1'b1;
        dec_web      = 1'b1;
        dec_dsel     = 1'b0;
        dec_lsel     = 1'b0;
        dec_we       = 1'b0;
        dec_imm      = '0;
        dec_uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                dec_uses_rs2 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec_legal = (funct3 != 3'b011);
                    case (funct3)
                        3'b001:  dec_alu = ALU_SLL;
                        3'b010:  dec_alu = ALU_SLT;
                        3'b100:  dec_alu = ALU_XOR;
                        3'b101:  dec_alu = ALU_SRL;
                        3'b110:  dec_alu = ALU_OR;
                        3'b111:  dec_alu = ALU_AND;
                        default: dec_alu = ALU_ADD;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_alu   = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_alu   = ALU_SRA;
                    end
                end
                dec_we = dec_legal;
            end
            OP_I: begin
                dec_imm   = i_imm;
                dec_src_b = SRC_B_IIMM;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
                    3'b010: begin dec_legal = 1'b1; dec_alu = ALU_SLT; end
                    3'b100: begin dec_legal = 1'b1; dec_alu = ALU_XOR; end
                    3'b110: begin dec_legal = 1'b1; dec_alu = ALU_OR;  end
                    3'b111: begin dec_legal = 1'b1; dec_alu = ALU_AND; end
                    3'b001: begin
                        dec_legal = (funct7 == 7'b0000000);
                        dec_alu   = ALU_SLL;
                        dec_src_b = SRC_B_SHAMT;
                        dec_imm   = shamt;
                    end
                    3'b101: begin
                        dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        dec_alu   = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                        dec_src_b = SRC_B_SHAMT;
                        dec_imm   = shamt;
                    end
                    default: ;
                endcase
                dec_we = dec_legal;
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_reb   = 1'b0;
                    dec_dsel  = 1'b1;
                    dec_src_b = SRC_B_LSIMM;
                    dec_imm   = i_imm;
                    dec_we    = 1'b1;
                end
            end
            OP_STORE: begin
                dec_uses_rs2 = 1'b1;
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    dec_web   = 1'b0;
                    dec_dsel  = 1'b1;
                    dec_lsel  = 1'b1;
                    dec_src_b = SRC_B_LSIMM;
                    dec_imm   = s_imm;
                end
            end
            default: ;
        endcase
        // Undecodable words travel as the bubble bundle so they cannot disturb state.
        if (!dec_legal) begin
            dec_alu   = ALU_ADD;
            dec_src_b = SRC_B_RS2;
            dec_reb   = 1'b1;
            dec_web   = 1'b1;
            dec_dsel  = 1'b0;
            dec_lsel  = 1'b0;
            dec_we    = 1'b0;
            dec_imm   = '0;
        end
    end

    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_alu_ctrl_q, ex_alu_ctrl_d;
    logic [2:0]        ex_alu_src_b_q, ex_alu_src_b_d;
    logic              ex_dmem_reb_q, ex_dmem_reb_d;
    logic              ex_dmem_web_q, ex_dmem_web_d;
    logic              ex_dmem_alu_sel_q, ex_dmem_alu_sel_d;
    logic              ex_ls_mux_sel_q, ex_ls_mux_sel_d;
    logic              ex_reg_we_q, ex_reg_we_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
    logic [XLEN-1:0]   ex_imm_q, ex_imm_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic advance;
    logic hazard;
    logic load_decode;
    logic load_bubble;
    logic stall_inc;

    // Only an LW in EX drives reb low, so that bit doubles as the "EX holds a load" flag.
    assign hazard = ex_valid_q && !ex_dmem_reb_q && (ex_rd_q != '0) &&
                    ((ex_rd_q == id_rs1) || (dec_uses_rs2 && (ex_rd_q == id_rs2)));
    assign advance     = !ex_valid_q || ex_ready;
    assign load_decode = !flush && advance && id_valid && !hazard;
    assign load_bubble = flush || (advance && !load_decode);
    assign stall_inc   = !flush && advance && id_valid && hazard;
    assign id_ready    = !flush && advance && !hazard;

    always_comb begin
        ex_valid_d        = ex_valid_q;
        ex_alu_ctrl_d     = ex_alu_ctrl_q;
        ex_alu_src_b_d    = ex_alu_src_b_q;
        ex_dmem_reb_d     = ex_dmem_reb_q;
        ex_dmem_web_d     = ex_dmem_web_q;
        ex_dmem_alu_sel_d = ex_dmem_alu_sel_q;
        ex_ls_mux_sel_d   = ex_ls_mux_sel_q;
        ex_reg_we_d       = ex_reg_we_q;
        ex_rd_d           = ex_rd_q;
        ex_rs1_d          = ex_rs1_q;
        ex_rs2_d          = ex_rs2_q;
        ex_imm_d          = ex_imm_q;
        stall_cnt_d       = stall_cnt_q;
        if (load_bubble) begin
            ex_valid_d        = 1'b0;
            ex_alu_ctrl_d     = ALU_ADD;
            ex_alu_src_b_d    = SRC_B_RS2;
            ex_dmem_reb_d     = 1'b1;
            ex_dmem_web_d     = 1'b1;
            ex_dmem_alu_sel_d = 1'b0;
            ex_ls_mux_sel_d   = 1'b0;
            ex_reg_we_d       = 1'b0;
            ex_rd_d           = '0;
            ex_rs1_d          = '0;
            ex_rs2_d          = '0;
            ex_imm_d          = '0;
        end else if (load_decode) begin
            ex_valid_d        = 1'b1;
            ex_alu_ctrl_d     = dec_alu;
            ex_alu_src_b_d    = dec_src_b;
            ex_dmem_reb_d     = dec_reb;
            ex_dmem_web_d     = dec_web;
            ex_dmem_alu_sel_d = dec_dsel;
            ex_ls_mux_sel_d   = dec_lsel;
            ex_reg_we_d       = dec_we;
            ex_rd_d           = dec_legal ? id_rd  : '0;
            ex_rs1_d          = dec_legal ? id_rs1 : '0;
            ex_rs2_d          = dec_legal ? id_rs2 : '0;
            ex_imm_d          = dec_imm;
        end
        if (stall_inc && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q        <= 1'b0;
            ex_alu_ctrl_q     <= ALU_ADD;
            ex_alu_src_b_q    <= SRC_B_RS2;
            ex_dmem_reb_q     <= 1'b1;
            ex_dmem_web_q     <= 1'b1;
            ex_dmem_alu_sel_q <= 1'b0;
            ex_ls_mux_sel_q   <= 1'b0;
            ex_reg_we_q       <= 1'b0;
            ex_rd_q           <= '0;
            ex_rs1_q          <= '0;
            ex_rs2_q          <= '0;
            ex_imm_q          <= '0;
            stall_cnt_q       <= '0;
        end else begin
            ex_valid_q        <= ex_valid_d;
            ex_alu_ctrl_q     <= ex_alu_ctrl_d;
            ex_alu_src_b_q    <= ex_alu_src_b_d;
            ex_dmem_reb_q     <= ex_dmem_reb_d;
            ex_dmem_web_q     <= ex_dmem_web_d;
            ex_dmem_alu_sel_q <= ex_dmem_alu_sel_d;
            ex_ls_mux_sel_q   <= ex_ls_mux_sel_d;
            ex_reg_we_q       <= ex_reg_we_d;
            ex_rd_q           <= ex_rd_d;
            ex_rs1_q          <= ex_rs1_d;
            ex_rs2_q          <= ex_rs2_d;
            ex_imm_q          <= ex_imm_d;
            stall_cnt_q       <= stall_cnt_d;
        end
    end

`ifdef ILLEGAL_INSN_TRAP_EN
    logic ex_illegal_q, ex_illegal_d;
    logic illegal_sticky_q, illegal_sticky_d;

    always_comb begin
        ex_illegal_d     = ex_illegal_q;
        illegal_sticky_d = illegal_sticky_q;
        if (load_bubble)
            ex_illegal_d = 1'b0;
        else if (load_decode) begin
            ex_illegal_d     = !dec_legal;
            illegal_sticky_d = illegal_sticky_q || !dec_legal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_illegal_q     <= 1'b0;
            illegal_sticky_q <= 1'b0;
        end else begin
            ex_illegal_q     <= ex_illegal_d;
            illegal_sticky_q <= illegal_sticky_d;
        end
    end

    assign ex_illegal     = ex_illegal_q;
    assign illegal_sticky = illegal_sticky_q;
`else
    assign ex_illegal     = 1'b0;
    assign illegal_sticky = 1'b0;
`endif

    assign ex_valid        = ex_valid_q;
    assign ex_alu_ctrl     = ex_alu_ctrl_q;
    assign ex_alu_src_a    = 1'b1;
    assign ex_alu_src_b    = ex_alu_src_b_q;
    assign ex_dmem_reb     = ex_dmem_reb_q;
    assign ex_dmem_web     = ex_dmem_web_q;
    assign ex_dmem_alu_sel = ex_dmem_alu_sel_q;
    assign ex_ls_mux_sel   = ex_ls_mux_sel_q;
    assign ex_reg_we       = ex_reg_we_q;
    assign ex_rd           = ex_rd_q;
    assign ex_rs1          = ex_rs1_q;
    assign ex_rs2          = ex_rs2_q;
    assign ex_imm          = ex_imm_q;
    assign stall_cnt       = stall_cnt_q;

endmodule
